// File: rtl/ts_os_generator.sv
// PCIe TS1/TS2 ordered-set burst generator driving a PIPE transmit interface.
// Emits 16-symbol ordered sets back to back until a count is reached or stop lands on a set boundary.
module ts_os_generator #(
    parameter logic [7:0] TS1_ID = 8'h4A,
    parameter logic [7:0] TS2_ID = 8'h45
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        os_type,
    input  logic [10:0] os_count,
    input  logic [7:0]  link_num,
    input  logic [4:0]  lane_num,
    input  logic        pad_link,
    input  logic        pad_lane,
    input  logic [7:0]  n_fts,
    input  logic [7:0]  rate_id,
    output logic [7:0]  TxData,
    output logic        TxDataK,
    output logic        TxDataValid,
    output logic        TxElecIdle,
    output logic        busy,
    output logic        done,
    output logic [10:0] sent_count
);

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] PAD = 8'hF7;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      r_state;
    logic [3:0]  r_sym_idx;
    logic        r_stop_seen;
    logic        r_os_type;
    logic [10:0] r_os_count;
    logic [7:0]  r_link_num;
    logic [4:0]  r_lane_num;
    logic        r_pad_link;
    logic        r_pad_lane;
    logic [7:0]  r_n_fts;
    logic [7:0]  r_rate_id;

    logic [3:0]  w_next_idx;
    logic [7:0]  w_next_data;
    logic        w_next_k;
    logic        w_last_sym;
    logic        w_count_hit;
    logic        w_end_burst;
    logic [10:0] w_sent_inc;

    assign w_next_idx  = r_sym_idx + 4'd1;
    assign w_last_sym  = (r_sym_idx == 4'd15);
    assign w_sent_inc  = (sent_count == 11'd2047) ? sent_count : sent_count + 11'd1;
    assign w_count_hit = (r_os_count != 11'd0) && ({1'b0, sent_count} + 12'd1 == {1'b0, r_os_count});
    // The live stop input counts too, so a stop on the symbol-15 cycle still closes this set.
    assign w_end_burst = w_count_hit || r_stop_seen || stop;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_k    = 1'b0;
        w_next_data = r_os_type ? TS2_ID : TS1_ID;
        case (w_next_idx)
            4'd0: begin
                w_next_k    = 1'b1;
                w_next_data = COM;
            end
            4'd1: begin
                w_next_k    = r_pad_link;
                w_next_data = r_pad_link ? PAD : r_link_num;
            end
            4'd2: begin
                w_next_k    = r_pad_lane;
                w_next_data = r_pad_lane ? PAD : {3'b000, r_lane_num};
            end
            4'd3:    w_next_data = r_n_fts;
            4'd4:    w_next_data = r_rate_id;
            4'd5:    w_next_data = 8'h00;
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sym_idx   <= 4'd0;
            r_stop_seen <= 1'b0;
            sent_count  <= 11'd0;
            done        <= 1'b0;
            busy        <= 1'b0;
            TxData      <= 8'h00;
            TxDataK     <= 1'b0;
            TxDataValid <= 1'b0;
            TxElecIdle  <= 1'b1;
            r_os_type   <= 1'b0;
            r_os_count  <= 11'd0;
            r_link_num  <= 8'h00;
            r_lane_num  <= 5'd0;
            r_pad_link  <= 1'b0;
            r_pad_lane  <= 1'b0;
            r_n_fts     <= 8'h00;
            r_rate_id   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= SEND;
                        r_sym_idx   <= 4'd0;
                        r_stop_seen <= 1'b0;
                        sent_count  <= 11'd0;
                        busy        <= 1'b1;
                        TxData      <= COM;
                        TxDataK     <= 1'b1;
                        TxDataValid <= 1'b1;
                        TxElecIdle  <= 1'b0;
                        r_os_type   <= os_type;
                        r_os_count  <= os_count;
                        r_link_num  <= link_num;
                        r_lane_num  <= lane_num;
                        r_pad_link  <= pad_link;
                        r_pad_lane  <= pad_lane;
                        r_n_fts     <= n_fts;
                        r_rate_id   <= rate_id;
                    end
                end
                SEND: begin
                    r_sym_idx <= w_next_idx;
                    if (w_last_sym) begin
                        sent_count  <= w_sent_inc;
                        r_stop_seen <= 1'b0;
                    end else begin
                        r_stop_seen <= r_stop_seen | stop;
                    end
                    if (w_last_sym && w_end_burst) begin
                        r_state     <= IDLE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        TxData      <= 8'h00;
                        TxDataK     <= 1'b0;
                        TxDataValid <= 1'b0;
                        TxElecIdle  <= 1'b1;
                    end else begin
                        TxData  <= w_next_data;
                        TxDataK <= w_next_k;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_os_generator.sv
// Self-checking bench for ts_os_generator: directed table, hand-written corner sequences
// and randomized bursts compared against a rule-level model of the ordered-set stream.
module tb_ts_os_generator;

    typedef struct {
        logic        os_type;
        logic [10:0] os_count;
        logic [7:0]  link;
        logic [4:0]  lane;
        logic        pad_link;
        logic        pad_lane;
        logic [7:0]  nfts;
        logic [7:0]  rate;
    } cfg_t;

    typedef struct {
        cfg_t cfg;
        int   stop_set;
        int   stop_sym;
        int   exp_sets;
    } vec_t;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        stop;
    logic        os_type;
    logic [10:0] os_count;
    logic [7:0]  link_num;
    logic [4:0]  lane_num;
    logic        pad_link;
    logic        pad_lane;
    logic [7:0]  n_fts;
    logic [7:0]  rate_id;
    logic [7:0]  TxData;
    logic        TxDataK;
    logic        TxDataValid;
    logic        TxElecIdle;
    logic        busy;
    logic        done;
    logic [10:0] sent_count;
    logic [31:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    ts_os_generator dut (
        .CLK(CLK), .reset(reset), .start(start), .stop(stop),
        .os_type(os_type), .os_count(os_count), .link_num(link_num), .lane_num(lane_num),
        .pad_link(pad_link), .pad_lane(pad_lane), .n_fts(n_fts), .rate_id(rate_id),
        .TxData(TxData), .TxDataK(TxDataK), .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle),
        .busy(busy), .done(done), .sent_count(sent_count)
    );

    assign obs = {8'h00, TxDataK, TxData, TxDataValid, TxElecIdle, busy, done, sent_count};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 2047) ? 2047 : v;
    endfunction

    function automatic logic [31:0] expw(input logic [8:0] kd, input logic v, input logic e,
                                         input logic b, input logic d, input int sent);
        logic [10:0] s;
        s = 11'(sat(sent));
        return {8'h00, kd, v, e, b, d, s};
    endfunction

    // Symbol i of one ordered set as {K, data}, straight from the TS1/TS2 layout.
    function automatic logic [8:0] model_sym(input cfg_t c, input int i);
        if (i == 0) return 9'h1BC;
        if (i == 1) return c.pad_link ? 9'h1F7 : {1'b0, c.link};
        if (i == 2) return c.pad_lane ? 9'h1F7 : {4'b0000, c.lane};
        if (i == 3) return {1'b0, c.nfts};
        if (i == 4) return {1'b0, c.rate};
        if (i == 5) return 9'h000;
        return c.os_type ? 9'h045 : 9'h04A;
    endfunction

    // Sets in a burst: count limit or the set carrying stop, whichever comes first.
    function automatic int model_sets(input cfg_t c, input int stop_set);
        int cnt;
        cnt = int'(c.os_count);
        if (stop_set != 0 && (cnt == 0 || stop_set < cnt)) return stop_set;
        return cnt;
    endfunction

    function automatic cfg_t mk_cfg(input logic t, input int cnt, input logic [7:0] link,
                                    input logic [4:0] lane, input logic pl, input logic pn,
                                    input logic [7:0] nf, input logic [7:0] rt);
        cfg_t c;
        c.os_type = t; c.os_count = 11'(cnt); c.link = link; c.lane = lane;
        c.pad_link = pl; c.pad_lane = pn; c.nfts = nf; c.rate = rt;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        c.os_type = r1[0]; c.os_count = r1[11:1]; c.link = r1[19:12]; c.lane = r1[24:20];
        c.pad_link = r1[25]; c.pad_lane = r1[26]; c.nfts = r2[7:0]; c.rate = r2[15:8];
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        os_type = c.os_type; os_count = c.os_count; link_num = c.link; lane_num = c.lane;
        pad_link = c.pad_link; pad_lane = c.pad_lane; n_fts = c.nfts; rate_id = c.rate;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts a burst, checks every symbol and the done cycle; returns in the done cycle.
    task automatic run_burst(input cfg_t c, input int stop_set, input int stop_sym,
                             input int exp_sets, input bit scramble, input bit hold);
        apply_cfg(c);
        start = 1'b1;
        stop  = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        for (int s = 1; s <= exp_sets; s++) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("sym set%0d idx%0d", s, i), obs,
                      expw(model_sym(c, i), 1'b1, 1'b0, 1'b1, 1'b0, s - 1));
                if (scramble) apply_cfg(rand_cfg());
                stop = (s == stop_set && i == stop_sym);
                if (s == exp_sets && i == 15) start = 1'b0;
                tick();
            end
        end
        stop = 1'b0;
        check("done cycle", obs, expw(9'h000, 1'b0, 1'b1, 1'b0, 1'b1, exp_sets));
    endtask

    task automatic idle_check(input string name, input int sent);
        tick();
        check(name, obs, expw(9'h000, 1'b0, 1'b1, 1'b0, 1'b0, sent));
    endtask

    vec_t vecs[6];

    initial begin
        cfg_t c;
        int   ss;
        int   si;
        int   n;

        vecs[0] = '{mk_cfg(1'b0, 2, 8'h00, 5'd0, 1'b1, 1'b1, 8'h20, 8'h02), 0, 0, 2};
        vecs[1] = '{mk_cfg(1'b1, 1, 8'h05, 5'd3, 1'b0, 1'b0, 8'h11, 8'h02), 0, 0, 1};
        vecs[2] = '{mk_cfg(1'b0, 0, 8'h3C, 5'd7, 1'b0, 1'b1, 8'h40, 8'h06), 3, 7, 3};
        vecs[3] = '{mk_cfg(1'b1, 5, 8'h81, 5'd31, 1'b1, 1'b0, 8'hFF, 8'h0E), 1, 15, 1};
        vecs[4] = '{mk_cfg(1'b0, 3, 8'h12, 5'd9, 1'b0, 1'b0, 8'h08, 8'h02), 3, 4, 3};
        vecs[5] = '{mk_cfg(1'b1, 0, 8'hA5, 5'd16, 1'b1, 1'b1, 8'h00, 8'h00), 2, 0, 2};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        apply_cfg(mk_cfg(1'b0, 0, 8'h00, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00));
        repeat (3) tick();
        check("reset state", obs, expw(9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        reset = 1'b0;
        idle_check("idle after reset", 0);

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].cfg, vecs[v].stop_set, vecs[v].stop_sym, vecs[v].exp_sets, 1'b0, 1'b0);
            idle_check($sformatf("idle after vec%0d", v), vecs[v].exp_sets);
        end

        // Start held through a burst with changing inputs, then a restart from the done cycle.
        c = mk_cfg(1'b1, 2, 8'h05, 5'd3, 1'b0, 1'b0, 8'h1F, 8'h02);
        run_burst(c, 0, 0, 2, 1'b1, 1'b1);
        c = mk_cfg(1'b0, 1, 8'h77, 5'd1, 1'b0, 1'b1, 8'h2A, 8'h04);
        run_burst(c, 0, 0, 1, 1'b0, 1'b0);
        idle_check("idle after chain", 1);

        // Reset in the middle of set 2 aborts with no done pulse and overrides start/stop.
        c = mk_cfg(1'b0, 4, 8'h33, 5'd2, 1'b0, 1'b0, 8'h10, 8'h02);
        apply_cfg(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                if (s == 2 && i == 9) break;
                check($sformatf("pre-reset set%0d idx%0d", s, i), obs,
                      expw(model_sym(c, i), 1'b1, 1'b0, 1'b1, 1'b0, s - 1));
                tick();
            end
        end
        check("symbol 9 before reset", obs, expw(model_sym(c, 9), 1'b1, 1'b0, 1'b1, 1'b0, 1));
        reset = 1'b1; start = 1'b1; stop = 1'b1;
        tick();
        check("abort by reset", obs, expw(9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        idle_check("no done after reset", 0);

        for (int r = 0; r < 8; r++) begin
            c = rand_cfg();
            c.os_count = 11'($urandom_range(0, 4));
            si = int'($urandom_range(0, 15));
            if (c.os_count == 11'd0) ss = int'($urandom_range(1, 3));
            else ss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            n = model_sets(c, ss);
            run_burst(c, ss, si, n, 1'b1, 1'b0);
            idle_check($sformatf("idle after random%0d", r), n);
        end

        // Long continuous burst to reach the sent_count ceiling.
        c = mk_cfg(1'b0, 0, 8'h01, 5'd1, 1'b0, 1'b0, 8'h00, 8'h00);
        run_burst(c, 2048, 3, model_sets(c, 2048), 1'b0, 1'b0);
        idle_check("saturated count held", 2047);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
